anc2_writer_sequencer: RTL and testbench
========================================

# anc2_writer_sequencer

Sequences the I/O Writer's print and control magnets for the ANC-2 alphanumeric coupler. It accepts one 6-bit character code at a time from the G-15 output path. For each code it:
- drives the shift magnet and waits for the shift basket to confirm position;
- energizes exactly one character or control magnet for a timed pulse;
- waits for the space/CR/TAB interlock to release;
- reports completion or error.

It sits between the ANC-2 output decode and the PL2A magnet/interlock connector. All timing is based on the 1 ms `tick_ms` strobe.

## Interface
Parameters:
- `PULSE_MS`, 20: magnet energize time, in ms ticks.
- `SHIFT_MS`, 40: minimum shift settle time before `shift_up` is checked.
- `DWELL_MS`, 10: post-strike recovery time before `done`.
- `TIMEOUT_MS`, 500: limit for the shift-confirm and interlock waits.

Ports:
- `CLOCK`  in  1: system clock; the single clock domain.
- `rst_n`  in  1: synchronous, active-low reset.
- `tick_ms`  in  1: one-cycle strobe, once per ms.
- `req_valid`  in  1: a request code is present.
- `req_code`  in  6: 0–43 select character magnet MAG_n; 44 SPACE, 45 CR, 46 TAB, 47 SHIFT-only; 48–63 illegal.
- `req_upper`  in  1: requested case (1 = upper); used for codes 0–43 and 47.
- `req_ready`  out  1: the sequencer is idle and will accept a request.
- `done`  out  1: one-cycle pulse when a request completes normally.
- `error`  out  1: one-cycle pulse on an illegal code or a timeout.
- `mag`  out  44: one-hot character magnet drive.
- `mag_space`, `mag_cr`, `mag_tab`  out  1 each: control magnet drives.
- `mag_shift`  out  1: shift magnet, held at level; equals the internal `upper_q`.
- `ilk`  in  1: space/CR/TAB interlock; 1 = mechanism busy.
- `shift_up`  in  1: shift basket feedback; 1 = basket up.

## Operation
- States: IDLE, SHIFT, FIRE, ILK_WAIT, DWELL, ERR.
- `req_ready` = (state == IDLE). All other outputs are registered.
- A request is accepted on the edge where `req_valid && req_ready`. `req_code` and `req_upper` are latched on that edge.

IDLE, on acceptance:
- Code 48–63 → ERR.
- Code 47 → SHIFT; `upper_q` ← `req_upper`.
- Code 0–43 with `req_upper != upper_q` → SHIFT; `upper_q` ← `req_upper`.
- Otherwise → FIRE.

SHIFT:
- Waits until the ms count ≥ `SHIFT_MS` and `shift_up == upper_q`.
- Then: code 47 → DWELL; otherwise → FIRE.
- If the ms count reaches `TIMEOUT_MS` first → ERR.

FIRE:
- Drives exactly one magnet: `mag[code]`, or `mag_space`, `mag_cr` or `mag_tab`.
- When the ms count reaches `PULSE_MS`, the magnet drops. Then: codes 44–46 → ILK_WAIT; codes 0–43 → DWELL.

ILK_WAIT:
- Leaves on the first `tick_ms` at which `ilk == 0` → DWELL.
- If the ms count reaches `TIMEOUT_MS` → ERR.

DWELL:
- When the ms count reaches `DWELL_MS`: `done` = 1 for one cycle, then → IDLE.

ERR:
- All character and control magnets off.
- `error` = 1 for one cycle, then → IDLE.
- `upper_q` keeps its value; there is no `done`.

Counting rules:
- The ms counter clears on every state entry.
- A `tick_ms` on the entry edge is not counted, so an N-tick interval lasts between N−1 and N ms.
- The counter is 10 bits wide and saturates; it never wraps.

Other rules:
- `req_valid` is ignored while busy. There is no queue.
- At most one of the 47 character/control magnets is high at any time.
- `mag_shift` is never pulsed; it only changes on acceptance.

## Timing
- Reset (`rst_n` low at an edge): state IDLE; `mag`, the control magnets and `mag_shift` = 0; `upper_q` = 0; `done` and `error` = 0; counter = 0.
- Reset mid-operation drops every magnet on that same edge. `req_ready` = 1 from the first cycle after reset.
- Acceptance to magnet: in the no-shift case, the magnet is high from the cycle after the acceptance edge.
- `req_ready` is low from the cycle after acceptance until the cycle after `done` or `error`.
- Total no-shift character time is `PULSE_MS` + `DWELL_MS` ticks, plus 3 cycles.
- A `tick_ms` coinciding with a state transition belongs to the old state only.

## Structure
Package `g15_anc2_pkg` holds:
- the code constants `CODE_SPACE`=44, `CODE_CR`=45, `CODE_TAB`=46, `CODE_SHIFT`=47, `CODE_MAX_CHAR`=43;
- the state enum `anc2_seq_state_t`.

Sub-module `anc2_ms_counter`:
- Inputs `clr` and `tick_ms`; saturating 10-bit count output.
- Instantiated once. The one-hot decode and the FSM stay in the top module.

## Test plan
Benches run with `PULSE_MS`=2, `SHIFT_MS`=3, `DWELL_MS`=1, `TIMEOUT_MS`=8.
- Code 2, lower case, from reset → `mag[2]` high for 2 ticks, `mag_shift` stays 0, `done` 1 tick later, `req_ready` returns to 1.
- Code 5, `req_upper`=1, with `shift_up` rising after 1 ms → `mag_shift`=1; `mag[5]` does not fire before tick 3; `done` asserts; a following code 5 upper does not toggle shift.
- Code 45 with `ilk` held high for 4 ms after the pulse → `mag_cr` pulses for 2 ticks, then `done` follows `ilk` falling; with `ilk` stuck at 1 → `error` at tick 8, no `done`.
- Code 47, upper, with `shift_up` stuck at 0 → `error` at tick 8, all magnets 0, `mag_shift` remains 1.
- Code 50 → `error` on the cycle after acceptance, no magnet activity.
- `rst_n` low while `mag[10]` is high → all magnets and `mag_shift` are 0 the next cycle; `req_ready`=1 after reset; `req_valid` pulses during a busy period are ignored.

Source files
------------

// File: rtl/g15_anc2_pkg.sv
// Shared code points and FSM state encoding for the ANC-2 I/O Writer sequencer.
package g15_anc2_pkg;

  localparam logic [5:0] CODE_MAX_CHAR = 6'd43;
  localparam logic [5:0] CODE_SPACE    = 6'd44;
  localparam logic [5:0] CODE_CR       = 6'd45;
  localparam logic [5:0] CODE_TAB      = 6'd46;
  localparam logic [5:0] CODE_SHIFT    = 6'd47;

  localparam int CNT_W     = 10;
  localparam int NUM_LANES = 47;  // 44 character magnets + space, CR, TAB

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FIRE,
    ST_ILK_WAIT,
    ST_DWELL,
    ST_ERR
  } anc2_seq_state_t;

endpackage

// File: rtl/anc2_ms_counter.sv
// Saturating millisecond counter. Clear wins over a coincident tick, so the tick on a
// state-entry edge is never credited to the new state.
module anc2_ms_counter
  import g15_anc2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick_ms,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr)                          count_d = '0;
    else if (tick_ms && (~&count_q))  count_d = count_q + 1'b1;
  end

  // NOTE: reset is synchronous here; rst_n is only examined on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/anc2_writer_sequencer.sv
// Sequences shift, strike and interlock phases for one character code at a time,
// driving the PL2A print/control magnets from registered outputs.
module anc2_writer_sequencer
  import g15_anc2_pkg::*;
#(
  parameter int PULSE_MS   = 20,
  parameter int SHIFT_MS   = 40,
  parameter int DWELL_MS   = 10,
  parameter int TIMEOUT_MS = 500
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        req_valid,
  input  logic [5:0]  req_code,
  input  logic        req_upper,
  output logic        req_ready,
  output logic        done,
  output logic        error,
  output logic [43:0] mag,
  output logic        mag_space,
  output logic        mag_cr,
  output logic        mag_tab,
  output logic        mag_shift,
  input  logic        ilk,
  input  logic        shift_up
);

  localparam logic [CNT_W-1:0] PULSE_LIM   = CNT_W'(PULSE_MS);
  localparam logic [CNT_W-1:0] SHIFT_LIM   = CNT_W'(SHIFT_MS);
  localparam logic [CNT_W-1:0] DWELL_LIM   = CNT_W'(DWELL_MS);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_MS);

  anc2_seq_state_t        state_d, state_q;
  logic [5:0]             code_d, code_q;
  logic                   upper_d, upper_q;
  logic                   done_d, done_q;
  logic                   error_d, error_q;
  logic [NUM_LANES-1:0]   lanes_d, lanes_q;
  logic [CNT_W-1:0]       count;
  logic                   clr;

  anc2_ms_counter u_ms_counter (
    .clk     (CLOCK),
    .rst_n   (rst_n),
    .clr     (clr),
    .tick_ms (tick_ms),
    .count   (count)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    upper_d = upper_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          code_d = req_code;
          if (req_code > CODE_SHIFT) begin
            state_d = ST_ERR;
          end else if (req_code == CODE_SHIFT ||
                       (req_code <= CODE_MAX_CHAR && req_upper != upper_q)) begin
            state_d = ST_SHIFT;
            upper_d = req_upper;
          end else begin
            state_d = ST_FIRE;
          end
        end
      end
      ST_SHIFT: begin
        if (count >= SHIFT_LIM && shift_up == upper_q)
          state_d = (code_q == CODE_SHIFT) ? ST_DWELL : ST_FIRE;
        else if (count >= TIMEOUT_LIM)
          state_d = ST_ERR;
      end
      ST_FIRE: begin
        if (count >= PULSE_LIM)
          state_d = (code_q > CODE_MAX_CHAR) ? ST_ILK_WAIT : ST_DWELL;
      end
      ST_ILK_WAIT: begin
        if (count >= TIMEOUT_LIM)   state_d = ST_ERR;
        else if (tick_ms && !ilk)   state_d = ST_DWELL;
      end
      ST_DWELL: begin
        // done is raised while still in DWELL so req_ready stays low through the pulse.
        if (done_q)                   state_d = ST_IDLE;
        else if (count >= DWELL_LIM)  done_d  = 1'b1;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    error_d = (state_d == ST_ERR) && (state_q != ST_ERR);
    lanes_d = (state_d == ST_FIRE) ? (NUM_LANES'(1) << code_d) : '0;
    clr     = (state_d != state_q);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      upper_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      upper_q <= upper_d;
      done_q  <= done_d;
      error_q <= error_d;
      lanes_q <= lanes_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign mag       = lanes_q[43:0];
  assign mag_space = lanes_q[44];
  assign mag_cr    = lanes_q[45];
  assign mag_tab   = lanes_q[46];
  assign mag_shift = upper_q;

endmodule

// File: tb/tb_anc2_writer_sequencer.sv
// Directed bench for anc2_writer_sequencer with short timing parameters; expected
// values are hand-derived cycle by cycle.
module tb_anc2_writer_sequencer;

  logic        CLOCK;
  logic        rst_n;
  logic        tick_ms;
  logic        req_valid;
  logic [5:0]  req_code;
  logic        req_upper;
  logic        req_ready;
  logic        done;
  logic        error;
  logic [43:0] mag;
  logic        mag_space;
  logic        mag_cr;
  logic        mag_tab;
  logic        mag_shift;
  logic        ilk;
  logic        shift_up;

  int total = 0;
  int bad   = 0;

  anc2_writer_sequencer #(
    .PULSE_MS   (2),
    .SHIFT_MS   (3),
    .DWELL_MS   (1),
    .TIMEOUT_MS (8)
  ) dut (
    .CLOCK     (CLOCK),
    .rst_n     (rst_n),
    .tick_ms   (tick_ms),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_upper (req_upper),
    .req_ready (req_ready),
    .done      (done),
    .error     (error),
    .mag       (mag),
    .mag_space (mag_space),
    .mag_cr    (mag_cr),
    .mag_tab   (mag_tab),
    .mag_shift (mag_shift),
    .ilk       (ilk),
    .shift_up  (shift_up)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic tick();
    tick_ms = 1'b1;
    step();
    tick_ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic accept(input logic [5:0] code, input logic upper);
    req_valid = 1'b1;
    req_code  = code;
    req_upper = upper;
    step();
    req_valid = 1'b0;
  endtask

  function automatic logic [63:0] ctrl();
    return {61'd0, mag_tab, mag_cr, mag_space};
  endfunction

  initial begin
    rst_n     = 1'b0;
    tick_ms   = 1'b0;
    req_valid = 1'b0;
    req_code  = '0;
    req_upper = 1'b0;
    ilk       = 1'b0;
    shift_up  = 1'b0;

    // Reset state
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_ready", req_ready, 1);
    check("rst_mag",   mag,       0);
    check("rst_ctrl",  ctrl(),    0);
    check("rst_shift", mag_shift, 0);
    check("rst_done",  done,      0);
    check("rst_error", error,     0);

    // Code 2, lower case, no shift
    accept(6'd2, 1'b0);
    check("c2_mag_on",    mag,       64'd4);
    check("c2_ready_low", req_ready, 0);
    check("c2_shift",     mag_shift, 0);
    tick();
    check("c2_mag_t1", mag, 64'd4);
    tick();
    check("c2_mag_t2", mag, 64'd4);
    step();
    check("c2_mag_off", mag, 0);
    tick();
    check("c2_no_done_yet", done, 0);
    step();
    check("c2_done",       done,      1);
    check("c2_ready_done", req_ready, 0);
    step();
    check("c2_done_clr", done,      0);
    check("c2_ready",    req_ready, 1);

    // Code 5 upper: shift first, basket rises after 1 ms
    shift_up = 1'b0;
    accept(6'd5, 1'b1);
    check("c5_shift_on", mag_shift, 1);
    check("c5_mag_wait", mag,       0);
    tick();
    shift_up = 1'b1;
    tick();
    check("c5_mag_t2", mag, 0);
    tick();
    check("c5_mag_t3", mag, 0);
    step();
    check("c5_fire", mag, 64'd32);
    tick(); tick(); step();
    check("c5_mag_off", mag, 0);
    tick(); step();
    check("c5_done", done, 1);
    step();
    check("c5_ready", req_ready, 1);

    // Second code 5 upper: no shift, fires at once; a busy request is ignored
    accept(6'd5, 1'b1);
    check("c5b_fire",  mag,       64'd32);
    check("c5b_shift", mag_shift, 1);
    req_valid = 1'b1;
    req_code  = 6'd3;
    tick();
    req_valid = 1'b0;
    check("c5b_busy_ignored", mag, 64'd32);
    tick(); step(); tick(); step();
    check("c5b_done", done, 1);
    step();
    check("c5b_ready", req_ready, 1);

    // Code 45 (CR), interlock busy 4 ms after the pulse
    ilk = 1'b1;
    accept(6'd45, 1'b1);
    check("cr_on",      ctrl(), 64'd2);
    check("cr_no_char", mag,    0);
    tick(); tick();
    check("cr_on_t2", ctrl(), 64'd2);
    step();
    check("cr_off", ctrl(), 0);
    ticks(4);
    check("cr_ilk_hold", done, 0);
    ilk = 1'b0;
    tick();
    check("cr_dwell_no_done", done,      0);
    check("cr_dwell_busy",    req_ready, 0);
    tick(); step();
    check("cr_done", done, 1);
    step();
    check("cr_ready", req_ready, 1);

    // Code 45 with interlock stuck busy -> timeout
    ilk = 1'b1;
    accept(6'd45, 1'b1);
    tick(); tick(); step();
    ticks(8);
    check("crto_no_err_yet", error, 0);
    step();
    check("crto_error",   error,  1);
    check("crto_no_done", done,   0);
    check("crto_ctrl",    ctrl(), 0);
    step();
    check("crto_err_clr", error,     0);
    check("crto_ready",   req_ready, 1);
    ilk = 1'b0;

    // Code 47 lower: shift-only, basket already down
    shift_up = 1'b0;
    accept(6'd47, 1'b0);
    check("sh_lower", mag_shift, 0);
    ticks(3); step();
    check("sh_no_fire", mag,  0);
    check("sh_no_done", done, 0);
    tick(); step();
    check("sh_done", done, 1);
    step();

    // Code 47 upper with basket stuck down -> timeout, shift level held
    accept(6'd47, 1'b1);
    check("sht_shift_on", mag_shift, 1);
    ticks(8); step();
    check("sht_error", error,     1);
    check("sht_mag",   mag,       0);
    check("sht_ctrl",  ctrl(),    0);
    check("sht_shift", mag_shift, 1);
    step();
    check("sht_ready", req_ready, 1);

    // Illegal code 50
    accept(6'd50, 1'b1);
    check("ill_error", error,     1);
    check("ill_mag",   mag,       0);
    check("ill_ready", req_ready, 0);
    step();
    check("ill_err_clr", error,     0);
    check("ill_ready2",  req_ready, 1);
    check("ill_shift",   mag_shift, 1);

    // Reset while mag[10] is energized
    accept(6'd10, 1'b1);
    check("r10_fire", mag, 64'd1 << 10);
    rst_n = 1'b0;
    step();
    check("r10_mag",   mag,       0);
    check("r10_shift", mag_shift, 0);
    check("r10_ready", req_ready, 1);
    rst_n = 1'b1;
    step();
    check("r10_ready_after", req_ready, 1);
    check("r10_done",        done,      0);
    check("r10_error",       error,     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
